e203_tcm_marb_ctrl: RTL and testbench

Parametrised next-generation TCM controller.
- Arbitrates NUM_MST ICB masters (for example EXT, LSU and IFU) onto one single-port SRAM.
- Arbitration is either fixed-priority or round-robin.
- Owns a 1-deep response holding stage, so the command path stalls under response backpressure without losing data.
- Flags out-of-range addresses with an error response and never touches the RAM for them.
- Tracks an IFU "holdup" hint for a selectable master index.
- Sits between the core's ICB splitters and the ITCM/DTCM RAM macro.

---
 rtl/e203_tcm_marb_ctrl_if.sv | 28 ++
 rtl/e203_tcm_marb_ctrl.sv | 170 +++++++++++++++++
 tb/tb_e203_tcm_marb_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_tcm_marb_ctrl_if.sv
// ICB master-side bundle for the TCM arbiter: NUM_MST packed command/response channels.
interface e203_tcm_marb_ctrl_if #(
  parameter int unsigned NUM_MST = 3,
  parameter int unsigned DW      = 32,
  parameter int unsigned MW      = DW / 8,
  parameter int unsigned AW      = 16
);
  logic [NUM_MST-1:0]    cmd_valid;
  logic [NUM_MST-1:0]    cmd_ready;
  logic [NUM_MST*AW-1:0] cmd_addr;
  logic [NUM_MST-1:0]    cmd_read;
  logic [NUM_MST*DW-1:0] cmd_wdata;
  logic [NUM_MST*MW-1:0] cmd_wmask;
  logic [NUM_MST-1:0]    rsp_valid;
  logic [NUM_MST-1:0]    rsp_ready;
  logic [NUM_MST-1:0]    rsp_err;
  logic [DW-1:0]         rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/e203_tcm_marb_ctrl.sv
// Multi-master TCM controller: arbitrates ICB masters onto one single-port SRAM
// with a 1-deep response stage, out-of-range error responses and a holdup hint.
module e203_tcm_marb_ctrl #(
  parameter int unsigned NUM_MST  = 3,
  parameter int unsigned DW       = 32,
  parameter int unsigned MW       = DW / 8,
  parameter int unsigned AW       = 16,
  parameter int unsigned AW_LSB   = 2,
  parameter int unsigned RAM_AW   = 14,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned HOLD_MST = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tcm_cgstop,
  input  logic                test_mode,
  e203_tcm_marb_ctrl_if.slave i_icb,
  output logic                holdup,
  output logic                tcm_active,
  output logic                ram_cs,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [MW-1:0]       ram_wem,
  output logic [DW-1:0]       ram_din,
  input  logic [DW-1:0]       ram_dout,
  output logic                ram_clk_en
);

  localparam int unsigned IW  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int unsigned WAW = AW - AW_LSB;

  // Modulo-NUM_MST increment used for the round-robin search and pointer update.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned ofs);
    int unsigned s;
    s = 32'(base) + ofs;
    if (s >= NUM_MST) s = s - NUM_MST;
    return IW'(s);
  endfunction

  logic [IW-1:0]      rr_ptr;
  logic               rsp_pend;
  logic [IW-1:0]      rsp_owner;
  logic               rsp_err_q;
  logic               rsp_rd;
  logic               rsp_first;
  logic [DW-1:0]      rsp_hold;
  logic               holdup_r;

  logic [NUM_MST-1:0] grant;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [IW-1:0]      arb_start;
  logic [IW-1:0]      arb_idx;

  logic [AW-1:0]      sel_addr;
  logic               sel_read;
  logic [DW-1:0]      sel_wdata;
  logic [MW-1:0]      sel_wmask;
  logic [WAW-1:0]     sel_word;
  logic               in_range;

  logic               rsp_hs;
  logic               slot_free;
  logic               accept;
  logic [DW-1:0]      rdata_c;
  logic               unused_lsb;

  // Grant: lowest index in fixed mode, first requester at/after rr_ptr in round-robin mode.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    arb_idx   = '0;
    arb_start = (ARB_MODE == 1) ? rr_ptr : '0;
    for (int unsigned k = 0; k < NUM_MST; k++) begin
      arb_idx = wrap_idx(arb_start, k);
      if (!gnt_any && i_icb.cmd_valid[arb_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = arb_idx;
      end
    end
    if (gnt_any) grant = NUM_MST'(1) << gnt_idx;
  end

  // Command fields of the granted master.
  always_comb begin
    sel_addr  = '0;
    sel_read  = 1'b0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      if (grant[i]) begin
        sel_addr  = i_icb.cmd_addr[i*AW +: AW];
        sel_read  = i_icb.cmd_read[i];
        sel_wdata = i_icb.cmd_wdata[i*DW +: DW];
        sel_wmask = i_icb.cmd_wmask[i*MW +: MW];
      end
    end
  end

  assign sel_word   = sel_addr[AW-1:AW_LSB];
  assign unused_lsb = ^sel_addr[AW_LSB-1:0];
  assign in_range   = ((sel_word >> RAM_AW) == '0);

  // A new command may enter when the holding stage is empty or draining this cycle.
  assign rsp_hs          = rsp_pend & i_icb.rsp_ready[rsp_owner];
  assign slot_free       = ~rsp_pend | rsp_hs;
  assign accept          = gnt_any & slot_free;
  assign i_icb.cmd_ready = slot_free ? grant : '0;

  // RAM drive; address/data/mask are zeroed whenever the RAM is not selected.
  assign ram_cs     = accept & in_range;
  assign ram_we     = ram_cs & ~sel_read;
  assign ram_addr   = ram_cs ? sel_word[RAM_AW-1:0] : '0;
  assign ram_wem    = (ram_cs & ~sel_read) ? sel_wmask : '0;
  assign ram_din    = ram_cs ? sel_wdata : '0;
  assign ram_clk_en = ram_cs | tcm_cgstop | test_mode;
  assign tcm_active = (|i_icb.cmd_valid) | rsp_pend;
  assign holdup     = holdup_r;

  // Read data: live RAM output on the first response cycle, held copy while stalled.
  always_comb begin
    rdata_c = '0;
    if (rsp_pend) begin
      if (rsp_first) rdata_c = rsp_rd ? ram_dout : '0;
      else           rdata_c = rsp_hold;
    end
  end

  assign i_icb.rsp_rdata = rdata_c;

  // Response valid/err decoded one-hot from the pending owner.
  always_comb begin
    i_icb.rsp_valid = '0;
    i_icb.rsp_err   = '0;
    if (rsp_pend) begin
      i_icb.rsp_valid[rsp_owner] = 1'b1;
      i_icb.rsp_err[rsp_owner]   = rsp_err_q;
    end
  end

  // Response holding stage, round-robin pointer and holdup tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      rsp_pend  <= 1'b0;
      rsp_owner <= '0;
      rsp_err_q <= 1'b0;
      rsp_rd    <= 1'b0;
      rsp_first <= 1'b0;
      rsp_hold  <= '0;
      holdup_r  <= 1'b0;
    end else begin
      if (accept) begin
        rsp_pend  <= 1'b1;
        rsp_owner <= gnt_idx;
        rsp_err_q <= ~in_range;
        rsp_rd    <= in_range & sel_read;
        rsp_first <= 1'b1;
        rr_ptr    <= wrap_idx(gnt_idx, 1);
      end else begin
        rsp_first <= 1'b0;
        if (rsp_hs) rsp_pend <= 1'b0;
      end
      if (rsp_pend && rsp_first) rsp_hold <= rdata_c;
      if (ram_cs) holdup_r <= (gnt_idx == IW'(HOLD_MST));
    end
  end

endmodule

// File: tb/tb_e203_tcm_marb_ctrl.sv
// Directed bench: fixed-priority instance for the datapath/holdup/reset cases,
// round-robin instance for grant rotation.
module tb_e203_tcm_marb_ctrl;

  localparam int unsigned NM = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned AW = 17;

  logic clk;
  logic rst_n;
  logic cgstop;
  logic tmode;
  logic [DW-1:0] dout;

  logic        f_holdup, f_active, f_cs, f_we, f_clk_en;
  logic [13:0] f_addr;
  logic [3:0]  f_wem;
  logic [31:0] f_din;
  logic        r_holdup, r_active, r_cs, r_we, r_clk_en;
  logic [13:0] r_addr;
  logic [3:0]  r_wem;
  logic [31:0] r_din;

  int total = 0;
  int bad   = 0;

  e203_tcm_marb_ctrl_if #(.NUM_MST(NM), .DW(DW), .MW(MW), .AW(AW)) f_if ();
  e203_tcm_marb_ctrl_if #(.NUM_MST(NM), .DW(DW), .MW(MW), .AW(AW)) r_if ();

  e203_tcm_marb_ctrl #(
    .NUM_MST(NM), .DW(DW), .MW(MW), .AW(AW), .AW_LSB(2), .RAM_AW(14),
    .ARB_MODE(0), .HOLD_MST(2)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n), .tcm_cgstop(cgstop), .test_mode(tmode),
    .i_icb(f_if.slave), .holdup(f_holdup), .tcm_active(f_active),
    .ram_cs(f_cs), .ram_we(f_we), .ram_addr(f_addr), .ram_wem(f_wem),
    .ram_din(f_din), .ram_dout(dout), .ram_clk_en(f_clk_en)
  );

  e203_tcm_marb_ctrl #(
    .NUM_MST(NM), .DW(DW), .MW(MW), .AW(AW), .AW_LSB(2), .RAM_AW(14),
    .ARB_MODE(1), .HOLD_MST(2)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n), .tcm_cgstop(cgstop), .test_mode(tmode),
    .i_icb(r_if.slave), .holdup(r_holdup), .tcm_active(r_active),
    .ram_cs(r_cs), .ram_we(r_we), .ram_addr(r_addr), .ram_wem(r_wem),
    .ram_din(r_din), .ram_dout(dout), .ram_clk_en(r_clk_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fset(input int m, input logic v, input logic [AW-1:0] a, input logic rd,
                      input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    f_if.cmd_valid[m]           = v;
    f_if.cmd_addr[m*AW +: AW]   = a;
    f_if.cmd_read[m]            = rd;
    f_if.cmd_wdata[m*DW +: DW]  = wd;
    f_if.cmd_wmask[m*MW +: MW]  = wm;
  endtask

  task automatic rset(input int m, input logic v, input logic [AW-1:0] a);
    r_if.cmd_valid[m]           = v;
    r_if.cmd_addr[m*AW +: AW]   = a;
    r_if.cmd_read[m]            = 1'b1;
    r_if.cmd_wdata[m*DW +: DW]  = '0;
    r_if.cmd_wmask[m*MW +: MW]  = '0;
  endtask

  initial begin
    rst_n  = 1'b0;
    cgstop = 1'b0;
    tmode  = 1'b0;
    dout   = '0;
    f_if.cmd_valid = '0; f_if.cmd_addr = '0; f_if.cmd_read = '0;
    f_if.cmd_wdata = '0; f_if.cmd_wmask = '0; f_if.rsp_ready = '0;
    r_if.cmd_valid = '0; r_if.cmd_addr = '0; r_if.cmd_read = '0;
    r_if.cmd_wdata = '0; r_if.cmd_wmask = '0; r_if.rsp_ready = '0;

    // Reset state
    #1;
    chk("rst_rsp_valid", f_if.rsp_valid, 0);
    chk("rst_holdup", f_holdup, 0);
    chk("rst_active", f_active, 0);
    chk("rst_cs", f_cs, 0);
    chk("rst_clk_en", f_clk_en, 0);
    chk("rst_rdata", f_if.rsp_rdata, 0);
    chk("rst_rr_rsp_valid", r_if.rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority: masters 0 and 2 contend
    @(negedge clk);
    fset(0, 1'b1, 17'h00020, 1'b1, 32'h0, 4'h0);
    fset(2, 1'b1, 17'h00040, 1'b1, 32'h0, 4'h0);
    f_if.rsp_ready = 3'b111;
    #1;
    chk("fp_c1_ready", f_if.cmd_ready, 3'b001);
    chk("fp_c1_cs", f_cs, 1);
    chk("fp_c1_addr", f_addr, 8);
    chk("fp_c1_we", f_we, 0);
    chk("fp_c1_active", f_active, 1);
    @(negedge clk);
    fset(0, 1'b0, 17'h0, 1'b0, 32'h0, 4'h0);
    dout = 32'h1111_1111;
    #1;
    chk("fp_c2_rsp_valid", f_if.rsp_valid, 3'b001);
    chk("fp_c2_rdata", f_if.rsp_rdata, 32'h1111_1111);
    chk("fp_c2_ready", f_if.cmd_ready, 3'b100);
    chk("fp_c2_addr", f_addr, 16);
    @(negedge clk);
    fset(2, 1'b0, 17'h0, 1'b0, 32'h0, 4'h0);
    dout = 32'h2222_2222;
    #1;
    chk("fp_c3_rsp_valid", f_if.rsp_valid, 3'b100);
    chk("fp_c3_rdata", f_if.rsp_rdata, 32'h2222_2222);
    chk("fp_c3_holdup", f_holdup, 1);
    chk("fp_c3_cs", f_cs, 0);
    @(negedge clk);
    dout = '0;
    #1;
    chk("fp_idle_rsp_valid", f_if.rsp_valid, 0);
    chk("fp_idle_active", f_active, 0);

    // Write then read back through the same word
    @(negedge clk);
    fset(1, 1'b1, 17'h00010, 1'b0, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("wr_cs", f_cs, 1);
    chk("wr_we", f_we, 1);
    chk("wr_addr", f_addr, 4);
    chk("wr_wem", f_wem, 4'hF);
    chk("wr_din", f_din, 32'hDEAD_BEEF);
    @(negedge clk);
    fset(1, 1'b1, 17'h00010, 1'b1, 32'h0, 4'h0);
    #1;
    chk("wr_rsp_valid", f_if.rsp_valid, 3'b010);
    chk("wr_rsp_rdata", f_if.rsp_rdata, 0);
    chk("wr_rsp_err", f_if.rsp_err, 0);
    chk("wr_holdup_clr", f_holdup, 0);
    chk("rd_ready", f_if.cmd_ready, 3'b010);
    chk("rd_we", f_we, 0);
    chk("rd_wem", f_wem, 0);
    chk("rd_addr", f_addr, 4);
    @(negedge clk);
    fset(1, 1'b0, 17'h0, 1'b0, 32'h0, 4'h0);
    dout = 32'hDEAD_BEEF;
    #1;
    chk("rd_rsp_valid", f_if.rsp_valid, 3'b010);
    chk("rd_rsp_rdata", f_if.rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", f_if.rsp_err, 0);

    // Stalled response holds first-cycle data and blocks new commands
    @(negedge clk);
    fset(2, 1'b1, 17'h00008, 1'b1, 32'h0, 4'h0);
    f_if.rsp_ready = 3'b011;
    #1;
    chk("st_acc_cs", f_cs, 1);
    chk("st_acc_addr", f_addr, 2);
    @(negedge clk);
    fset(2, 1'b0, 17'h0, 1'b0, 32'h0, 4'h0);
    fset(0, 1'b1, 17'h0000C, 1'b1, 32'h0, 4'h0);
    dout = 32'hAAAA_0001;
    #1;
    chk("st1_rsp_valid", f_if.rsp_valid, 3'b100);
    chk("st1_rdata", f_if.rsp_rdata, 32'hAAAA_0001);
    chk("st1_ready", f_if.cmd_ready, 0);
    chk("st1_cs", f_cs, 0);
    chk("st1_holdup", f_holdup, 1);
    @(negedge clk);
    dout = 32'hBBBB_0002;
    #1;
    chk("st2_rdata", f_if.rsp_rdata, 32'hAAAA_0001);
    chk("st2_ready", f_if.cmd_ready, 0);
    chk("st2_cs", f_cs, 0);
    @(negedge clk);
    dout = 32'hCCCC_0003;
    #1;
    chk("st3_rdata", f_if.rsp_rdata, 32'hAAAA_0001);
    chk("st3_ready", f_if.cmd_ready, 0);
    chk("st3_cs", f_cs, 0);
    @(negedge clk);
    f_if.rsp_ready = 3'b111;
    dout = 32'hDDDD_0004;
    #1;
    chk("b2b_rdata", f_if.rsp_rdata, 32'hAAAA_0001);
    chk("b2b_rsp_valid", f_if.rsp_valid, 3'b100);
    chk("b2b_ready", f_if.cmd_ready, 3'b001);
    chk("b2b_cs", f_cs, 1);
    chk("b2b_addr", f_addr, 3);
    @(negedge clk);
    fset(0, 1'b0, 17'h0, 1'b0, 32'h0, 4'h0);
    dout = 32'hC0C0_C0C0;
    #1;
    chk("b2b_next_rsp_valid", f_if.rsp_valid, 3'b001);
    chk("b2b_next_rdata", f_if.rsp_rdata, 32'hC0C0_C0C0);
    chk("b2b_next_holdup", f_holdup, 0);

    // Out-of-range access: error response, no RAM access, holdup untouched
    @(negedge clk);
    fset(2, 1'b1, 17'h00004, 1'b1, 32'h0, 4'h0);
    #1;
    chk("oor_pre_cs", f_cs, 1);
    @(negedge clk);
    fset(2, 1'b0, 17'h0, 1'b0, 32'h0, 4'h0);
    fset(1, 1'b1, 17'h10000, 1'b1, 32'h0, 4'h0);
    dout = 32'h0000_0005;
    #1;
    chk("oor_ready", f_if.cmd_ready, 3'b010);
    chk("oor_cs", f_cs, 0);
    chk("oor_addr", f_addr, 0);
    chk("oor_clk_en", f_clk_en, 0);
    chk("oor_prev_rdata", f_if.rsp_rdata, 5);
    @(negedge clk);
    fset(1, 1'b0, 17'h0, 1'b0, 32'h0, 4'h0);
    dout = 32'hFFFF_FFFF;
    cgstop = 1'b1;
    #1;
    chk("oor_rsp_valid", f_if.rsp_valid, 3'b010);
    chk("oor_rsp_err", f_if.rsp_err, 3'b010);
    chk("oor_rdata", f_if.rsp_rdata, 0);
    chk("oor_holdup", f_holdup, 1);
    chk("cgstop_clk_en", f_clk_en, 1);
    @(negedge clk);
    cgstop = 1'b0;
    tmode  = 1'b1;
    #1;
    chk("tmode_clk_en", f_clk_en, 1);
    chk("tmode_rsp_valid", f_if.rsp_valid, 0);

    // Holdup clear by another master, then reset mid-response
    @(negedge clk);
    tmode = 1'b0;
    fset(1, 1'b1, 17'h00020, 1'b0, 32'h0000_0001, 4'h3);
    #1;
    chk("hu_wr_cs", f_cs, 1);
    chk("hu_wr_wem", f_wem, 4'h3);
    @(negedge clk);
    fset(1, 1'b0, 17'h0, 1'b0, 32'h0, 4'h0);
    fset(2, 1'b1, 17'h00024, 1'b1, 32'h0, 4'h0);
    f_if.rsp_ready = 3'b011;
    #1;
    chk("hu_clr", f_holdup, 0);
    chk("hu_rd_ready", f_if.cmd_ready, 3'b100);
    @(negedge clk);
    fset(2, 1'b0, 17'h0, 1'b0, 32'h0, 4'h0);
    dout = 32'h0000_0077;
    #1;
    chk("hu_set", f_holdup, 1);
    chk("hu_rsp_valid", f_if.rsp_valid, 3'b100);
    chk("hu_rdata", f_if.rsp_rdata, 32'h77);
    rst_n = 1'b0;
    #1;
    chk("mrst_rsp_valid", f_if.rsp_valid, 0);
    chk("mrst_holdup", f_holdup, 0);
    chk("mrst_rdata", f_if.rsp_rdata, 0);
    chk("mrst_active", f_active, 0);
    @(negedge clk);
    rst_n = 1'b1;
    f_if.rsp_ready = 3'b111;
    #1;
    chk("post_rst_cs", f_cs, 0);
    chk("post_rst_rsp_valid", f_if.rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("post_rst2_rsp_valid", f_if.rsp_valid, 0);

    // Round-robin rotation with all masters requesting, including 2 -> 0 wrap
    @(negedge clk);
    rset(0, 1'b1, 17'h00100);
    rset(1, 1'b1, 17'h00104);
    rset(2, 1'b1, 17'h00108);
    r_if.rsp_ready = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), r_if.cmd_ready, 64'(3'b001 << (k % 3)));
      chk($sformatf("rr%0d_cs", k), r_cs, 1);
      chk($sformatf("rr%0d_addr", k), r_addr, 64'(14'h40 + 14'(k % 3)));
      if (k > 0)
        chk($sformatf("rr%0d_rsp_valid", k), r_if.rsp_valid, 64'(3'b001 << ((k - 1) % 3)));
      @(negedge clk);
    end
    rset(0, 1'b0, 17'h0);
    rset(1, 1'b0, 17'h0);
    rset(2, 1'b0, 17'h0);
    #1;
    chk("rr_last_rsp_valid", r_if.rsp_valid, 3'b100);
    chk("rr_idle_cs", r_cs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
